// File: rtl/w5300_pkg.sv
// Shared constants for the W5300 socket receive sequencer.
// Command word layout: {op, addr[9:0], data[15:0]}, op 1 = read, 0 = write.
// Register offsets are socket-0 values; socket N adds 10'h040*N.
package w5300_pkg;

    localparam logic ADDR_OP_RD = 1'b1;
    localparam logic ADDR_OP_WR = 1'b0;

    localparam logic [9:0] REG_CR       = 10'h202;
    localparam logic [9:0] REG_RX_RSR0  = 10'h228;
    localparam logic [9:0] REG_RX_RSR2  = 10'h22a;
    localparam logic [9:0] REG_RX_FIFOR = 10'h230;

    localparam logic [15:0] CR_RECV = 16'h0040;

    localparam logic [26:0] CMD_IDLE = {1'b1, 10'h3ff, 16'hffff};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSR0,
        ST_RSR2,
        ST_HDR,
        ST_DATA,
        ST_RECV
    } rx_state_t;

    function automatic logic [26:0] mk_cmd(input logic op, input logic [9:0] addr,
                                           input logic [15:0] data);
        return {op, addr, data};
    endfunction

endpackage

// File: rtl/w5300_rx_word_buf.sv
// One-entry holding register between the bus read response and the
// payload stream. A pushed word stays on out_* until out_ready accepts it.
// The sequencer never pushes while a word is held.
// Ports: clk, rst (sync, active high), in_valid/in_data/in_last/in_bytes
// (push side), out_valid/out_ready/out_data/out_last/out_bytes (stream side).
module w5300_rx_word_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [1:0]  out_bytes
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_last  <= 1'b0;
            out_bytes <= 2'd0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_bytes <= in_bytes;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_bytes <= 2'd0;
        end
    end

endmodule

// File: rtl/w5300_udp_rx_seq.sv
// UDP receive command sequencer for W5300 socket N.
// Polls Sn_RX_RSR, reads the 8-byte UDP header from Sn_RX_FIFOR, streams
// the payload words out (or drains them if oversized), then issues RECV.
// Ports: clk, rst (sync, active high), en; cmd_valid/cmd_ready/cmd to the
// bus engine; rsp_valid/rsp_data read responses; hdr_valid/src_ip/src_port/
// pkt_len header; out_valid/out_ready/out_data/out_last/out_bytes payload;
// pkt_drop oversized-packet pulse; busy.
//
// state   | meaning
// IDLE    | wait POLL_GAP clocks between polls (only while en)
// RSR0    | read RX_RSR0, keep bit 0 as rsr[16]
// RSR2    | read RX_RSR2, nothing pending -> IDLE
// HDR     | four FIFO reads: ip hi, ip lo, port, length
// DATA    | one FIFO read per payload word, each drained before the next
// RECV    | write RECV to Sn_CR
module w5300_udp_rx_seq
    import w5300_pkg::*;
#(
    parameter int N        = 0,
    parameter int POLL_GAP = 256,
    parameter int MAX_LEN  = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [26:0] cmd,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data,
    output logic        hdr_valid,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] pkt_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [1:0]  out_bytes,
    output logic        pkt_drop,
    output logic        busy
);

    localparam logic [9:0] SOCK_OFS = 10'(N * 64);
    localparam logic [9:0] A_CR     = REG_CR + SOCK_OFS;
    localparam logic [9:0] A_RSR0   = REG_RX_RSR0 + SOCK_OFS;
    localparam logic [9:0] A_RSR2   = REG_RX_RSR2 + SOCK_OFS;
    localparam logic [9:0] A_FIFO   = REG_RX_FIFOR + SOCK_OFS;

    localparam int              PT_W        = $clog2(POLL_GAP + 1);
    localparam logic [PT_W-1:0] POLL_RELOAD = PT_W'(POLL_GAP - 1);
    localparam logic [15:0]     MAX_LEN_W   = 16'(MAX_LEN);

    rx_state_t       state;
    logic [PT_W-1:0] poll_tmr;
    logic            rd_pend;
    logic [1:0]      hdr_idx;
    logic [16:0]     words_left;
    logic            drop;
    logic            rsr_hi;
    logic [31:0]     ip_s;
    logic [15:0]     port_s;

    logic        rsp_fire;
    logic        cmd_acc;
    logic        can_issue;
    logic        buf_push;
    logic        buf_last;
    logic [1:0]  buf_bytes;

    assign rsp_fire  = rd_pend & rsp_valid;
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign can_issue = !cmd_valid && !rd_pend;
    assign buf_last  = (words_left == 17'd1);
    assign buf_bytes = (buf_last && pkt_len[0]) ? 2'd1 : 2'd2;
    assign buf_push  = (state == ST_DATA) && rsp_fire && !drop;
    assign busy      = (state != ST_IDLE);

    w5300_rx_word_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (buf_push),
        .in_data   (rsp_data),
        .in_last   (buf_last),
        .in_bytes  (buf_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_bytes (out_bytes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            poll_tmr   <= POLL_RELOAD;
            rd_pend    <= 1'b0;
            hdr_idx    <= 2'd0;
            words_left <= 17'd0;
            drop       <= 1'b0;
            rsr_hi     <= 1'b0;
            ip_s       <= 32'h0;
            port_s     <= 16'h0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_IDLE;
            hdr_valid  <= 1'b0;
            src_ip     <= 32'h0;
            src_port   <= 16'h0;
            pkt_len    <= 16'h0;
            pkt_drop   <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            pkt_drop  <= 1'b0;

            // Accepted read leaves exactly one response outstanding.
            if (cmd_acc) begin
                cmd_valid <= 1'b0;
                cmd       <= CMD_IDLE;
                rd_pend   <= cmd[26];
            end

            case (state)
                ST_IDLE: begin
                    if (!en) begin
                        poll_tmr <= POLL_RELOAD;
                    end else if (poll_tmr == '0) begin
                        poll_tmr  <= POLL_RELOAD;
                        state     <= ST_RSR0;
                        cmd_valid <= 1'b1;
                        cmd       <= mk_cmd(ADDR_OP_RD, A_RSR0, 16'h0000);
                    end else begin
                        poll_tmr <= poll_tmr - 1'b1;
                    end
                end
                ST_RSR0: begin
                    if (rsp_fire) begin
                        rd_pend   <= 1'b0;
                        rsr_hi    <= rsp_data[0];
                        state     <= ST_RSR2;
                        cmd_valid <= 1'b1;
                        cmd       <= mk_cmd(ADDR_OP_RD, A_RSR2, 16'h0000);
                    end
                end
                ST_RSR2: begin
                    if (rsp_fire) begin
                        rd_pend <= 1'b0;
                        if ({rsr_hi, rsp_data} == 17'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_HDR;
                            hdr_idx   <= 2'd0;
                            cmd_valid <= 1'b1;
                            cmd       <= mk_cmd(ADDR_OP_RD, A_FIFO, 16'h0000);
                        end
                    end
                end
                ST_HDR: begin
                    if (rsp_fire) begin
                        rd_pend <= 1'b0;
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: ip_s[31:16] <= rsp_data;
                            2'd1: ip_s[15:0]  <= rsp_data;
                            2'd2: port_s      <= rsp_data;
                            2'd3: begin
                                // Publish all header fields together.
                                src_ip     <= ip_s;
                                src_port   <= port_s;
                                pkt_len    <= rsp_data;
                                hdr_valid  <= 1'b1;
                                words_left <= ({1'b0, rsp_data} + 17'd1) >> 1;
                                drop       <= (rsp_data > MAX_LEN_W);
                                if (rsp_data == 16'h0000) begin
                                    state     <= ST_RECV;
                                    cmd_valid <= 1'b1;
                                    cmd       <= mk_cmd(ADDR_OP_WR, A_CR, CR_RECV);
                                end else begin
                                    state <= ST_DATA;
                                end
                            end
                            default: ;
                        endcase
                        if (hdr_idx != 2'd3) begin
                            cmd_valid <= 1'b1;
                            cmd       <= mk_cmd(ADDR_OP_RD, A_FIFO, 16'h0000);
                        end
                    end
                end
                ST_DATA: begin
                    if (rsp_fire) begin
                        rd_pend    <= 1'b0;
                        words_left <= words_left - 17'd1;
                        if (drop && buf_last) pkt_drop <= 1'b1;
                    end else if (can_issue && (!out_valid || out_ready)) begin
                        // Next read only once the held word is leaving.
                        cmd_valid <= 1'b1;
                        if (words_left == 17'd0) begin
                            state <= ST_RECV;
                            cmd   <= mk_cmd(ADDR_OP_WR, A_CR, CR_RECV);
                        end else begin
                            cmd <= mk_cmd(ADDR_OP_RD, A_FIFO, 16'h0000);
                        end
                    end
                end
                ST_RECV: begin
                    if (cmd_acc) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_udp_rx_seq.sv
module tb_w5300_udp_rx_seq;

    localparam int GAP = 20;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        cmd_valid, cmd_ready;
    logic [26:0] cmd;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        hdr_valid;
    logic [31:0] src_ip;
    logic [15:0] src_port, pkt_len;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic [1:0]  out_bytes;
    logic        pkt_drop, busy;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] A_RSR0 = 10'h268;
    localparam logic [9:0] A_RSR2 = 10'h26a;
    localparam logic [9:0] A_FIFO = 10'h270;
    localparam logic [9:0] A_CR   = 10'h242;
    localparam logic [26:0] IDLE_CMD = 27'h7ffffff;

    always #5 clk = ~clk;

    w5300_udp_rx_seq #(.N(1), .POLL_GAP(GAP), .MAX_LEN(1472)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .hdr_valid(hdr_valid), .src_ip(src_ip), .src_port(src_port), .pkt_len(pkt_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_bytes(out_bytes),
        .pkt_drop(pkt_drop), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input string tag, output int n);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cmd_seen"}, 64'(cmd_valid), 64'd1);
    endtask

    task automatic serve_rd(input string tag, input logic [9:0] addr,
                            input logic [15:0] data, input int stall);
        int n;
        wait_cmd(tag, n);
        chk({tag, "_cmd"}, 64'(cmd), 64'({1'b1, addr, 16'h0000}));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, 64'(cmd_valid), 64'd1);
            chk({tag, "_stall_cmd"}, 64'(cmd), 64'({1'b1, addr, 16'h0000}));
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = data;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = 16'h0000;
    endtask

    task automatic serve_wr(input string tag, input logic [9:0] addr, input logic [15:0] data);
        int n;
        wait_cmd(tag, n);
        chk({tag, "_cmd"}, 64'(cmd), 64'({1'b0, addr, data}));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, "_done"}, 64'(cmd_valid), 64'd0);
    endtask

    task automatic do_header(input string tag, input logic [15:0] rsr0, input logic [15:0] rsr2,
                             input logic [31:0] ip, input logic [15:0] port,
                             input logic [15:0] len, input int stall);
        serve_rd({tag, "_rsr0"}, A_RSR0, rsr0, 0);
        serve_rd({tag, "_rsr2"}, A_RSR2, rsr2, 0);
        serve_rd({tag, "_h0"}, A_FIFO, ip[31:16], stall);
        serve_rd({tag, "_h1"}, A_FIFO, ip[15:0], 0);
        serve_rd({tag, "_h2"}, A_FIFO, port, 0);
        serve_rd({tag, "_h3"}, A_FIFO, len, 0);
        chk({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd1);
        chk({tag, "_src_ip"}, 64'(src_ip), 64'(ip));
        chk({tag, "_src_port"}, 64'(src_port), 64'(port));
        chk({tag, "_pkt_len"}, 64'(pkt_len), 64'(len));
        @(negedge clk);
        chk({tag, "_hdr_pulse"}, 64'(hdr_valid), 64'd0);
    endtask

    task automatic take_word(input string tag, input logic [15:0] data, input logic last,
                             input logic [1:0] bytes, input int stall);
        int n;
        serve_rd(tag, A_FIFO, data, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(data));
        chk({tag, "_last"}, 64'(out_last), 64'(last));
        chk({tag, "_bytes"}, 64'(out_bytes), 64'(bytes));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_data"}, 64'(out_data), 64'(data));
            chk({tag, "_hold_nocmd"}, 64'(cmd_valid), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd"}, 64'(cmd), 64'(IDLE_CMD));
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
        chk({tag, "_hdr_fields"}, {src_ip, src_port, pkt_len}, 64'd0);
        chk({tag, "_out"}, 64'({out_valid, out_data, out_last, out_bytes}), 64'd0);
        chk({tag, "_pkt_drop"}, 64'(pkt_drop), 64'd0);
    endtask

    initial begin
        int  n;
        logic seen;
        rst = 1'b1; en = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_data = 16'h0000; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;
        en  = 1'b1;

        // Empty poll: two RSR reads, back to IDLE, next poll one gap later.
        serve_rd("empty_rsr0", A_RSR0, 16'h0000, 0);
        serve_rd("empty_rsr2", A_RSR2, 16'h0000, 0);
        chk("empty_busy", 64'(busy), 64'd0);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("empty_poll_gap", 64'(n), 64'(GAP));

        // 8-byte packet.
        do_header("p8", 16'h0000, 16'h0010, 32'hc0a86f01, 16'd7000, 16'd8, 0);
        take_word("p8_w0", 16'h1111, 1'b0, 2'd2, 0);
        take_word("p8_w1", 16'h2222, 1'b0, 2'd2, 0);
        take_word("p8_w2", 16'h3333, 1'b0, 2'd2, 0);
        take_word("p8_w3", 16'h4444, 1'b1, 2'd2, 0);
        serve_wr("p8_recv", A_CR, 16'h0040);
        chk("p8_busy", 64'(busy), 64'd0);

        // 5-byte packet, pending count only in rsr[16], stall on word 2.
        do_header("p5", 16'h0001, 16'h0000, 32'h0a000001, 16'h0035, 16'd5, 0);
        take_word("p5_w0", 16'haabb, 1'b0, 2'd2, 0);
        take_word("p5_w1", 16'hccdd, 1'b0, 2'd2, 10);
        take_word("p5_w2", 16'hee00, 1'b1, 2'd1, 0);
        serve_wr("p5_recv", A_CR, 16'h0040);

        // Oversized packet is drained silently.
        do_header("p1500", 16'h0000, 16'h0600, 32'h0a000002, 16'h0044, 16'd1500, 0);
        seen = 1'b0;
        for (int i = 0; i < 750; i++) begin
            serve_rd("drop_rd", A_FIFO, 16'(i), 0);
            if (out_valid !== 1'b0) seen = 1'b1;
            if (i == 749) chk("drop_pulse", 64'(pkt_drop), 64'd1);
            else if (pkt_drop !== 1'b0) seen = 1'b1;
        end
        chk("drop_no_out_no_early_pulse", 64'(seen), 64'd0);
        @(negedge clk);
        chk("drop_pulse_end", 64'(pkt_drop), 64'd0);
        serve_wr("drop_recv", A_CR, 16'h0040);

        // Stalled header command, then reset in the middle of DATA.
        do_header("pr", 16'h0000, 16'h0004, 32'h01020304, 16'h0050, 16'd4, 5);
        serve_rd("pr_w0", A_FIFO, 16'h5a5a, 0);
        chk("pr_w0_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_poll_gap", 64'(n), 64'(GAP));
        serve_rd("midrst_rsr0", A_RSR0, 16'h0000, 0);
        serve_rd("midrst_rsr2", A_RSR2, 16'h0000, 0);

        // With en low no polling happens.
        en   = 1'b0;
        seen = 1'b0;
        repeat (3 * GAP) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) seen = 1'b1;
        end
        chk("en_low_no_poll", 64'(seen), 64'd0);
        chk("en_low_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
